irq_pending_latch4: RTL and testbench

//  Upstream stage of the 4-to-2 priority encoder in the interrupt path.
//  - Synchronises four request lines and captures events into sticky pending bits.
//  - Applies a mask and drives the masked vector into the encoder's d input.
//  - Takes the encoder's q/v back and runs an irq/ack handshake.
//  - On each ack, clears the pending bit of the source it serviced.

---
 rtl/irq_pending_latch4.sv | 151 +++++++++++++++
 tb/tb_irq_pending_latch4.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch4.sv
// irq_pending_latch4
// Front end of the interrupt path that feeds an external 4-to-2 priority
// encoder. Raw request lines are synchronised and captured into sticky
// pending bits. The masked pending vector is driven to the encoder, and the
// encoder's answer is turned into an irq/ack handshake with the consumer.
// The pending bit of each serviced source is cleared when its ack arrives.

module irq_pending_latch4 #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_in,
    input  logic       mask_we,
    input  logic [3:0] mask_wdata,
    output logic [3:0] pend_d,
    input  logic [1:0] enc_q,
    input  logic       enc_v,
    output logic       irq,
    output logic [1:0] irq_id,
    input  logic       ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0] req_s;
    logic [3:0] req_s_d;
    logic [3:0] set_vec;
    logic [3:0] clr_vec;
    logic [3:0] pending;
    logic [3:0] mask;

    // Shift the asynchronous request lines through the synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= req_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Keep the previous synchronised value so rising edges can be detected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_s_d <= '0;
        end else begin
            req_s_d <= req_s;
        end
    end

    // Select edge or level capture for the events that set pending bits
    always_comb begin
        set_vec = req_s;
        if (EDGE_MODE) begin
            set_vec = req_s & ~req_s_d;
        end
    end

    // Clear only the serviced source, and only during the single CLEAR cycle
    always_comb begin
        clr_vec = 4'b0000;
        if (state == CLEAR) begin
            clr_vec = 4'b0001 << irq_id;
        end
    end

    // Sticky pending bits; a new event wins over a clear landing on the same bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 4'b0000;
        end else begin
            pending <= set_vec | (pending & ~clr_vec);
        end
    end

    // Mask register, loaded by the write strobe and visible from the next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= 4'b0000;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end

    // Encoder input is built purely from registers, so req_in never reaches it combinationally
    assign pend_d = pending & mask;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; ack only matters while the interrupt is asserted
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enc_v) begin
                    state_nxt = ASSERT;
                end
            end
            ASSERT: begin
                if (ack) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM output decode; irq depends on the state register only, never on pend_d
    always_comb begin
        irq = 1'b0;
        if (state == ASSERT) begin
            irq = 1'b1;
        end
    end

    // Capture the encoder's choice on leaving IDLE and hold it until the next capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_id <= 2'd0;
        end else if (state == IDLE && enc_v) begin
            irq_id <= enc_q;
        end
    end

endmodule

// File: tb/tb_irq_pending_latch4.sv
// tb_irq_pending_latch4
// Drives one edge-mode and one level-mode instance. Each has a behavioural
// priority encoder closing the loop. Expected interrupt ids are queued when
// requests are applied and are consumed as each interrupt is serviced.

module tb_irq_pending_latch4;

    logic clk = 1'b0;
    logic rst;

    logic [3:0] req_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic [3:0] pend_d;
    logic [1:0] enc_q;
    logic       enc_v;
    logic       irq;
    logic [1:0] irq_id;
    logic       ack;

    logic [3:0] l_req_in;
    logic       l_mask_we;
    logic [3:0] l_mask_wdata;
    logic [3:0] l_pend_d;
    logic [1:0] l_enc_q;
    logic       l_enc_v;
    logic       l_irq;
    logic [1:0] l_irq_id;
    logic       l_ack;

    logic       sel;
    logic       cur_irq;
    logic [1:0] cur_id;
    logic [3:0] cur_pend;

    logic [1:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always #5 clk = ~clk;

    // Count clock cycles so the repeat spacing can be measured
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] prio(input logic [3:0] d);
        if (d[3]) return 2'd3;
        if (d[2]) return 2'd2;
        if (d[1]) return 2'd1;
        return 2'd0;
    endfunction

    assign enc_q   = prio(pend_d);
    assign enc_v   = |pend_d;
    assign l_enc_q = prio(l_pend_d);
    assign l_enc_v = |l_pend_d;

    assign cur_irq  = sel ? l_irq    : irq;
    assign cur_id   = sel ? l_irq_id : irq_id;
    assign cur_pend = sel ? l_pend_d : pend_d;

    irq_pending_latch4 #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .pend_d(pend_d), .enc_q(enc_q),
        .enc_v(enc_v), .irq(irq), .irq_id(irq_id), .ack(ack)
    );

    irq_pending_latch4 #(.SYNC_STAGES(2), .EDGE_MODE(1'b0)) dut_lvl (
        .clk(clk), .rst(rst), .req_in(l_req_in), .mask_we(l_mask_we),
        .mask_wdata(l_mask_wdata), .pend_d(l_pend_d), .enc_q(l_enc_q),
        .enc_v(l_enc_v), .irq(l_irq), .irq_id(l_irq_id), .ack(l_ack)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setReq(input logic [3:0] r);
        if (sel) l_req_in = r;
        else     req_in   = r;
    endtask

    task automatic writeMask(input logic [3:0] m);
        if (sel) begin l_mask_we = 1'b1; l_mask_wdata = m; end
        else     begin mask_we   = 1'b1; mask_wdata   = m; end
        tick(1);
        l_mask_we = 1'b0;
        mask_we   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] exp_ids);
        for (int i = 3; i >= 0; i--) begin
            if (exp_ids[i]) exp_q.push_back(2'(i));
        end
        setReq(r);
        tick(1);
        setReq(4'b0000);
    endtask

    task automatic waitIrq(input string tag, input int budget);
        int n;
        n = 0;
        while (!cur_irq && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput({tag, "_irq"}, {7'd0, cur_irq}, 8'd1);
    endtask

    task automatic popCheck(input string tag);
        logic [1:0] e;
        e = 2'bxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checkOutput({tag, "_id"}, {6'd0, cur_id}, {6'd0, e});
    endtask

    task automatic pulseAck();
        if (sel) l_ack = 1'b1;
        else     ack   = 1'b1;
        tick(1);
        l_ack = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic serviceIrq(input string tag);
        waitIrq(tag, 40);
        popCheck(tag);
        pulseAck();
        checkOutput({tag, "_clr_irq"}, {7'd0, cur_irq}, 8'd0);
        tick(1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int tp;
        rst = 1'b1; sel = 1'b0;
        req_in = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0;
        l_req_in = '0; l_mask_we = 1'b0; l_mask_wdata = '0; l_ack = 1'b0;
        tick(3);
        checkOutput("rst_irq", {7'd0, irq}, 8'd0);
        checkOutput("rst_pend", {4'd0, pend_d}, 8'd0);
        checkOutput("rst_id", {6'd0, irq_id}, 8'd0);
        rst = 1'b0;
        tick(1);

        // Single edge on source 1
        writeMask(4'hF);
        applyStimulus(4'b0010, 4'b0010);
        waitIrq("t1", 40);
        checkOutput("t1_pend", {4'd0, pend_d}, 8'h02);
        popCheck("t1");
        pulseAck();
        checkOutput("t1_clr_irq", {7'd0, irq}, 8'd0);
        tick(1);
        checkOutput("t1_pend_after", {4'd0, pend_d}, 8'h00);
        checkOutput("t1_irq_after", {7'd0, irq}, 8'd0);

        // Two simultaneous sources, highest index first
        applyStimulus(4'b1010, 4'b1010);
        waitIrq("t2a", 40);
        checkOutput("t2_pend", {4'd0, pend_d}, 8'h0A);
        popCheck("t2a");
        pulseAck();
        checkOutput("t2a_clr_irq", {7'd0, irq}, 8'd0);
        tick(1);
        checkOutput("t2_pend_mid", {4'd0, pend_d}, 8'h02);
        serviceIrq("t2b");
        checkOutput("t2_pend_end", {4'd0, pend_d}, 8'h00);

        // Masked source latches but stays hidden until unmasked
        writeMask(4'b0000);
        applyStimulus(4'b0100, 4'b0000);
        tick(8);
        checkOutput("t3_pend_masked", {4'd0, pend_d}, 8'h00);
        checkOutput("t3_irq_masked", {7'd0, irq}, 8'd0);
        mask_we = 1'b1; mask_wdata = 4'b0100;
        tick(1);
        mask_we = 1'b0;
        checkOutput("t3_pend_unmask", {4'd0, pend_d}, 8'h04);
        checkOutput("t3_irq_early", {7'd0, irq}, 8'd0);
        exp_q.push_back(2'd2);
        serviceIrq("t3");
        checkOutput("t3_pend_end", {4'd0, pend_d}, 8'h00);

        // New event on source 0 lands exactly in its own CLEAR cycle
        writeMask(4'hF);
        applyStimulus(4'b0001, 4'b0001);
        waitIrq("t4a", 40);
        popCheck("t4a");
        req_in = 4'b0001;
        tick(1);
        req_in = 4'b0000;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        checkOutput("t4_clr_irq", {7'd0, irq}, 8'd0);
        tick(1);
        checkOutput("t4_pend_kept", {4'd0, pend_d}, 8'h01);
        exp_q.push_back(2'd0);
        serviceIrq("t4b");
        checkOutput("t4_pend_end", {4'd0, pend_d}, 8'h00);

        // Level mode: held source repeats every 3 cycles, stops after release
        sel = 1'b1;
        writeMask(4'hF);
        l_req_in = 4'b1000;
        exp_q.push_back(2'd3);
        waitIrq("t5_0", 40);
        popCheck("t5_0");
        tp = cyc;
        for (int i = 0; i < 3; i++) begin
            pulseAck();
            exp_q.push_back(2'd3);
            waitIrq("t5_rep", 40);
            popCheck("t5_rep");
            checkOutput("t5_period", 8'(cyc - tp), 8'd3);
            tp = cyc;
        end
        l_req_in = 4'b0000;
        pulseAck();
        exp_q.push_back(2'd3);
        waitIrq("t5_last", 40);
        popCheck("t5_last");
        pulseAck();
        checkOutput("t5_clr_irq", {7'd0, l_irq}, 8'd0);
        tick(10);
        checkOutput("t5_irq_stop", {7'd0, l_irq}, 8'd0);
        checkOutput("t5_pend_end", {4'd0, l_pend_d}, 8'h00);

        // Reset while an interrupt is asserted
        sel = 1'b0;
        applyStimulus(4'b0100, 4'b0100);
        waitIrq("t6a", 40);
        popCheck("t6a");
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_irq", {7'd0, irq}, 8'd0);
        checkOutput("t6_rst_pend", {4'd0, pend_d}, 8'h00);
        checkOutput("t6_rst_id", {6'd0, irq_id}, 8'd0);
        tick(2);
        rst = 1'b0;
        tick(10);
        checkOutput("t6_quiet_irq", {7'd0, irq}, 8'd0);
        applyStimulus(4'b0010, 4'b0000);
        tick(8);
        checkOutput("t6_mask_cleared", {4'd0, pend_d}, 8'h00);
        checkOutput("t6_no_irq", {7'd0, irq}, 8'd0);
        writeMask(4'hF);
        checkOutput("t6_pend_unmask", {4'd0, pend_d}, 8'h02);
        exp_q.push_back(2'd1);
        serviceIrq("t6b");
        checkOutput("t6_pend_end", {4'd0, pend_d}, 8'h00);

        checkOutput("sb_empty", 8'(exp_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
